// File: rtl/adder_seq.sv
// Chunked add/subtract: one CHUNK-bit slice per cycle from LSB up, so latency is WIDTH/CHUNK cycles from acceptance to out_valid.
// Valid/ready on both sides; DONE holds result and flags until out_ready, and no new operation is accepted until then.
module adder_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;      // already inverted for subtract
    logic             carry;  // running carry between chunks
  } opnd_t;

  typedef struct packed {
    logic cout;
    logic zero;
    logic neg;
    logic ovf;
  } flags_t;

  state_t           state_q, state_d;
  opnd_t            opnd_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q, sum_d;
  flags_t           flags_q, flags_d;
  logic [31:0]      shamt;
  logic [CHUNK-1:0] a_chk, b_chk, s_chk;
  logic             c_chk;
  logic             accept, last;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt_q == LAST);

  // Current slice: shift the operands down rather than indexing, so the
  // same logic serves every CHUNK/WIDTH combination.
  always_comb begin
    shamt = 32'(cnt_q) * 32'(CHUNK);
    a_chk = CHUNK'(opnd_q.a >> shamt);
    b_chk = CHUNK'(opnd_q.b >> shamt);
    {c_chk, s_chk} = {1'b0, a_chk} + {1'b0, b_chk} + {{CHUNK{1'b0}}, opnd_q.carry};
    sum_d = (sum_q & ~(CMASK << shamt)) | (WIDTH'(s_chk) << shamt);
    flags_d.cout = c_chk;
    flags_d.zero = (sum_d == '0);
    flags_d.neg  = sum_d[WIDTH-1];
    flags_d.ovf  = (opnd_q.a[WIDTH-1] == opnd_q.b[WIDTH-1]) &&
                   (sum_d[WIDTH-1] != opnd_q.a[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      flags_q <= '0;
    end else begin
      if (accept) begin
        // Subtract is a + ~b + !cin; carry-in polarity folds into the carry register.
        opnd_q <= '{a: a, b: (sub ? ~b : b), carry: (sub ? ~cin : cin)};
        cnt_q  <= '0;
      end
      if (state_q == BUSY) begin
        sum_q        <= sum_d;
        opnd_q.carry <= c_chk;
        cnt_q        <= cnt_q + 1'b1;
        if (last) flags_q <= flags_d;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = flags_q.cout;
  assign zero = flags_q.zero;
  assign neg  = flags_q.neg;
  assign ovf  = flags_q.ovf;

endmodule

// File: tb/tb_adder_seq.sv
// Bench for adder_seq: 8-bit/4-bit instance for vectors and handshake corners, 16-bit instances sweep CHUNK.
module tb_adder_seq;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        zero;
    logic        neg;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    bit         s;
    bit         c;
    logic [7:0] sum;
    logic [3:0] fl;  // {cout, zero, neg, ovf}
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  logic       clk, rst_n, rst16_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, sum;
  logic       sub, cin, cout, zero, neg, ovf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  adder_seq #(.WIDTH(8), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .zero(zero), .neg(neg), .ovf(ovf)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic and signed range test.
  function automatic res_t model(input int w, input longint a_i, input longint b_i, input bit s, input bit c);
    res_t   r;
    longint m, half, raw, sa, sb, sr, ci;
    ci   = c;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    raw  = s ? (a_i - b_i - ci) : (a_i + b_i + ci);
    r.sum  = 16'(raw & m);
    r.cout = s ? (a_i >= b_i + ci) : (raw > m);
    sa = (a_i >= half) ? a_i - 2 * half : a_i;
    sb = (b_i >= half) ? b_i - 2 * half : b_i;
    sr = s ? (sa - sb - ci) : (sa + sb + ci);
    r.ovf  = (sr < -half) || (sr >= half);
    r.zero = (r.sum == 16'd0);
    r.neg  = r.sum[w-1];
    return r;
  endfunction

  task automatic do_op(input string nm, input logic [7:0] ta, input logic [7:0] tb_,
                       input logic ts, input logic tc, input res_t e,
                       input int hold, input bit disturb);
    int lat;
    @(negedge clk);
    check({nm, "_in_ready_idle"}, in_ready, 1);
    a = ta; b = tb_; sub = ts; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check({nm, "_in_ready_busy"}, in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 50) begin
      if (disturb) begin
        in_valid = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
        sub = 1'($urandom); cin = 1'($urandom);
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check({nm, "_latency"}, lat, 2);
    check({nm, "_sum"}, sum, e.sum[7:0]);
    check({nm, "_flags"}, {cout, zero, neg, ovf}, {e.cout, e.zero, e.neg, e.ovf});
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      check({nm, "_hold_valid"}, out_valid, 1);
      check({nm, "_hold_in_ready"}, in_ready, 0);
      check({nm, "_hold_sum"}, sum, e.sum[7:0]);
      check({nm, "_hold_flags"}, {cout, zero, neg, ovf}, {e.cout, e.zero, e.neg, e.ovf});
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({nm, "_valid_after_hs"}, out_valid, 0);
  endtask

  // CHUNK sweep at WIDTH=16, each instance self-driven and running alongside the main sequence.
  for (genvar gi = 0; gi < 3; gi++) begin : g16
    localparam int CH = (gi == 0) ? 1 : (gi == 1) ? 4 : 16;
    localparam int NC = 16 / CH;
    logic        iv, ir, ov, orr, gsub, gcin, gco, gz, gn, go;
    logic [15:0] ga, gb, gs;
    bit          done;

    adder_seq #(.WIDTH(16), .CHUNK(CH)) u_dut (
      .clk(clk), .rst_n(rst16_n), .in_valid(iv), .in_ready(ir),
      .a(ga), .b(gb), .sub(gsub), .cin(gcin), .out_valid(ov), .out_ready(orr),
      .sum(gs), .cout(gco), .zero(gz), .neg(gn), .ovf(go)
    );

    initial begin
      res_t        e;
      int          lat;
      logic [15:0] ta, tb_;
      logic        ts, tc;
      done = 1'b0; iv = 1'b0; orr = 1'b0; ga = '0; gb = '0; gsub = 1'b0; gcin = 1'b0;
      wait (rst16_n === 1'b1);
      for (int k = 0; k < 16; k++) begin
        if (k == 0) begin
          ta = 16'hFFFF; tb_ = 16'h0001; ts = 1'b0; tc = 1'b0;
        end else begin
          ta = 16'($urandom); tb_ = 16'($urandom); ts = 1'($urandom); tc = 1'($urandom);
        end
        e = model(16, ta, tb_, ts, tc);
        @(negedge clk);
        check($sformatf("w16c%0d_in_ready", CH), ir, 1);
        ga = ta; gb = tb_; gsub = ts; gcin = tc; iv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv = 1'b0;
        lat = 0;
        while (!ov && lat < 100) begin
          @(posedge clk);
          lat++;
          @(negedge clk);
        end
        check($sformatf("w16c%0d_latency", CH), lat, NC);
        check($sformatf("w16c%0d_sum", CH), gs, e.sum);
        check($sformatf("w16c%0d_flags", CH), {gco, gz, gn, go}, {e.cout, e.zero, e.neg, e.ovf});
        if (k == 0) check($sformatf("w16c%0d_ffff_cout_zero", CH), {gs, gco}, 17'h00001);
        orr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        orr = 1'b0;
      end
      done = 1'b1;
    end
  end

  initial begin
    vec_t tbl[9];
    res_t e;
    int   t;

    tbl[0] = '{8'h3A, 8'h25, 1'b0, 1'b0, 8'h5F, 4'b0000};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 4'b1100};
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 4'b0011};
    tbl[3] = '{8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 4'b0010};
    tbl[4] = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h7E, 4'b1001};
    tbl[5] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 4'b0000};
    tbl[6] = '{8'h55, 8'h55, 1'b1, 1'b0, 8'h00, 4'b1100};
    tbl[7] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 4'b0010};
    tbl[8] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 4'b1101};

    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    rst_n = 1'b1; rst16_n = 1'b1;
    #2 rst_n = 1'b0; rst16_n = 1'b0;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_flags", {cout, zero, neg, ovf}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1; rst16_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      e = '0;
      e.sum = {8'h00, tbl[i].sum};
      {e.cout, e.zero, e.neg, e.ovf} = tbl[i].fl;
      do_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c, e, 0, 1'b0);
    end

    // Back-pressure: DONE held for 5 cycles.
    e = model(8, 8'h3A, 8'h25, 1'b0, 1'b0);
    do_op("backpressure", 8'h3A, 8'h25, 1'b0, 1'b0, e, 5, 1'b0);

    // Inputs thrashed while BUSY must not disturb the captured operation.
    e = model(8, 8'h10, 8'h20, 1'b1, 1'b0);
    do_op("busy_noise", 8'h10, 8'h20, 1'b1, 1'b0, e, 0, 1'b1);

    // Asynchronous reset in the middle of BUSY, off the clock edges.
    @(negedge clk);
    a = 8'h3A; b = 8'h25; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_sum", sum, 0);
    check("rst_mid_flags", {cout, zero, neg, ovf}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    e = model(8, 8'h7F, 8'h01, 1'b0, 1'b0);
    do_op("after_rst", 8'h7F, 8'h01, 1'b0, 1'b0, e, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      logic [7:0] ra, rb;
      logic       rs, rc;
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom); rc = 1'($urandom);
      e = model(8, ra, rb, rs, rc);
      do_op($sformatf("rand%0d", i), ra, rb, rs, rc, e, i % 3, 1'b0);
    end

    t = 0;
    while (!(g16[0].done && g16[1].done && g16[2].done) && t < 5000) begin
      @(posedge clk);
      t++;
    end
    check("sweep_complete", {g16[0].done, g16[1].done, g16[2].done}, 3'b111);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
